// File: rtl/seg_scan_bcd.sv
// seg_scan_bcd: sequential double-dabble BCD converter driving a multiplexed
// common-anode seven-segment display with blanking, blinking and overflow.
module seg_scan_bcd #(
    parameter int DIGITS       = 8,
    parameter int VAL_W        = 14,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [VAL_W-1:0]  value,
    input  logic              lz_blank,
    input  logic [DIGITS-1:0] blink_mask,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              busy
);
    localparam int ND = (VAL_W + 4) / 3;
    localparam int BW = 4 * ND;
    localparam int NP = (ND > DIGITS) ? ND : DIGITS;
    localparam int CW = $clog2(VAL_W + 1);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_e;

    state_e          state_q, state_d;
    logic [VAL_W-1:0] shadow_q, shadow_d;
    logic [VAL_W-1:0] sh_q, sh_d;
    logic [BW-1:0]    acc_q, acc_d;
    logic [BW-1:0]    acc_adj;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [4*NP-1:0]  disp_q, disp_d;
    logic             ovf_q, ovf_d;
    logic             ovf_new;

    logic [PW-1:0]     pre_q, pre_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [FW-1:0]     frm_q, frm_d;
    logic              off_q, off_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [DIGITS-1:0] upz;
    logic [3:0]        nib;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        unique case (d)
            4'd0:    dec7 = 7'b1000000;
            4'd1:    dec7 = 7'b1111001;
            4'd2:    dec7 = 7'b0100100;
            4'd3:    dec7 = 7'b0110000;
            4'd4:    dec7 = 7'b0011001;
            4'd5:    dec7 = 7'b0010010;
            4'd6:    dec7 = 7'b0000010;
            4'd7:    dec7 = 7'b1111000;
            4'd8:    dec7 = 7'b0000000;
            4'd9:    dec7 = 7'b0010000;
            default: dec7 = SEG_BLANK;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            sh_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            disp_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            sh_q     <= sh_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            disp_q   <= disp_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        sh_d     = sh_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        disp_d   = disp_q;
        ovf_d    = ovf_q;
        acc_adj  = acc_q;
        ovf_new  = 1'b0;
        for (int n = 0; n < ND; n++) begin
            if (acc_q[4*n +: 4] >= 4'd5)
                acc_adj[4*n +: 4] = acc_q[4*n +: 4] + 4'd3;
        end
        // Nibbles beyond the scanned digits mean the value cannot be shown.
        for (int n = DIGITS; n < ND; n++) begin
            if (acc_q[4*n +: 4] != 4'd0)
                ovf_new = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (!valid_q || value != shadow_q) begin
                    shadow_d = value;
                    sh_d     = value;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CONV;
                end
            end
            CONV: begin
                {acc_d, sh_d} = {acc_adj[BW-2:0], sh_q, 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(VAL_W - 1))
                    state_d = LOAD;
            end
            LOAD: begin
                disp_d          = '0;
                disp_d[BW-1:0]  = acc_q;
                ovf_d           = ovf_new;
                valid_d         = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == CONV);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
            idx_q <= '0;
            frm_q <= '0;
            off_q <= 1'b0;
            seg_q <= SEG_ZERO;
            an_q  <= ~DIGITS'(1);
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            frm_q <= frm_d;
            off_q <= off_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    always_comb begin
        pre_d = pre_q + PW'(1);
        idx_d = idx_q;
        frm_d = frm_q;
        off_d = off_q;
        if (pre_q == PW'(REFRESH_DIV - 1)) begin
            pre_d = '0;
            if (idx_q == IW'(DIGITS - 1)) begin
                idx_d = '0;
                if (frm_q == FW'(BLINK_FRAMES - 1)) begin
                    frm_d = '0;
                    off_d = ~off_q;
                end else begin
                    frm_d = frm_q + FW'(1);
                end
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    // upz[i]: every displayed nibble from i upwards is zero.
    always_comb begin
        logic z;
        z   = 1'b1;
        upz = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            z      = z & (disp_q[4*i +: 4] == 4'd0);
            upz[i] = z;
        end
    end

    // Pattern is built for the digit about to be enabled so seg and an move together.
    always_comb begin
        nib  = disp_q[4*idx_d +: 4];
        an_d = ~(DIGITS'(1) << idx_d);
        if (ovf_q)
            seg_d = SEG_DASH;
        else if (blink_mask[idx_d] && off_d)
            seg_d = SEG_BLANK;
        else if (lz_blank && idx_d != '0 && upz[idx_d])
            seg_d = SEG_BLANK;
        else
            seg_d = dec7(nib);
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: doc/seg_scan_bcd.md
Name: seg_scan_bcd

Overview:
Parametrised successor to the game's score display driver. Converts a binary value to BCD with a sequential double-dabble engine. Time-multiplexes the result across DIGITS common-anode seven-segment digits, with leading-zero blanking, per-digit blinking and overflow indication. Sits between the Tetris score/level logic and the board's seg/an pins.

Parameters:
DIGITS, 8, number of scanned digits (1..8)
VAL_W, 14, width of binary input value
REFRESH_DIV, 100000, clk cycles each digit is held active (>=2)
BLINK_FRAMES, 64, full scan frames per blink half-period (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
value  input  VAL_W  unsigned binary number to display
lz_blank  input  1  1 = blank leading zeros (digit 0 never blanked)
blink_mask  input  DIGITS  1 = digit blinks
seg  output  7  {g,f,e,d,c,b,a}, active-low
an  output  DIGITS  digit enables, active-low, one-hot-zero
busy  output  1  conversion in progress

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM=IDLE; shadow value=0, valid=0; display BCD register=0, ovf=0.
  - Prescaler=0, digit index=0, frame counter=0, blink phase=ON.
  - an = all ones except bit0=0; seg=7'b1000000 ("0"); busy=0.
- FSM, one step per clk:
  - IDLE: if valid=0 or value!=shadow, latch value into shadow and working shift reg, clear BCD accumulator, go CONV, busy=1.
  - CONV: VAL_W iterations, one per cycle. Each iteration adds 3 to every BCD nibble >=5, then shifts left 1. After the last, go LOAD.
  - LOAD: copy accumulator to display register, set ovf if the result needs more than DIGITS digits, set valid=1, busy=0, go IDLE.
- Latency: value change to display update = VAL_W+2 cycles.
- value changing during CONV is ignored until IDLE; then a new conversion starts.
- Reset mid-CONV aborts; the display returns to "0".
- Accumulator width is 4*ceil((VAL_W+2)/3) bits. Overflow = any nibble at or above index DIGITS is nonzero.
- Scanning:
  - Prescaler counts 0..REFRESH_DIV-1.
  - On wrap, digit index increments, wrapping DIGITS-1 -> 0.
  - an[i]=0 only for i=index; changes exactly on prescaler wrap.
  - seg is registered together with an, with no one-cycle skew.
- Frame = index wrap to 0. Frame counter counts 0..BLINK_FRAMES-1; on wrap, blink phase toggles.
- Per-digit seg priority, highest first:
  1. ovf=1: dash 7'b0111111 on every digit.
  2. blink_mask[i]=1 and phase=OFF: blank 7'b1111111.
  3. lz_blank=1, i>0, and all nibbles i..DIGITS-1 are zero: blank.
  4. Otherwise the decoded nibble.
- Decode, 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Nibble >9 cannot occur; decode it as blank.

Test Plan:
- Release reset with value=12, DIGITS=8, REFRESH_DIV=4, lz_blank=1 -> busy high for 14 cycles starting the first cycle after reset release. Display register reads 12 at cycle 16. Scan shows digit0 seg=0100100 ("2"), digit1 1111001 ("1"), digits2..7 1111111. an steps 11111110, 11111101, ... every 4 cycles and wraps after 32.
- value=16383, lz_blank=0 -> digits 0..4 show 3,8,3,6,1; digits 5..7 show "0" (1000000).
- Change value 12->345 during CONV of the 12 conversion -> display shows 12 first, then 345 exactly 16 cycles after the next IDLE.
- DIGITS=4, value=12345 -> ovf=1, all four digits 0111111 regardless of blink_mask.
- blink_mask=8'b00000001, BLINK_FRAMES=2 -> digit0 alternates "2"/blank every 2 frames (64 cycles at REFRESH_DIV=4); other digits unaffected.
- Assert reset mid-CONV and mid-scan -> an=11111110 and seg=1000000 immediately (asynchronous). After release, a full conversion reruns.
